// File: rtl/counter_seq_ctrl_pkg.sv
// Shared definitions for the counter start/stop sequencer and its counter core.
package counter_seq_ctrl_pkg;

   localparam int unsigned CSC_WIDTH         = 4;
   localparam int unsigned CSC_DEFAULT_LIMIT = 14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Busy is defined over RUN and HOLD only; DONE is a one-cycle non-busy state.
   function automatic logic state_is_busy(input state_t s);
      return (s == ST_RUN) || (s == ST_HOLD);
   endfunction

endpackage

// File: rtl/counter_seq_ctrl_core.sv
// WIDTH-bit synchronous up-counter with clear, enable and a terminal-count flag.
module sync_counter_core
   import counter_seq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = CSC_WIDTH
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             En,
   input  logic             Clr,
   input  logic [WIDTH-1:0] Limit,
   output logic [WIDTH-1:0] Count,
   output logic             Tc
);

   logic [WIDTH-1:0] r_count;

   // Clear wins over enable so a wrap never lands on limit+1.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_count <= '0;
      end else if (Clr) begin
         r_count <= '0;
      end else if (En) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign Count = r_count;
   assign Tc    = (r_count == Limit);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Start/stop sequencer driving a sync_counter_core: one-shot or continuous runs
// with hold, reporting Busy plus one-cycle Done and Wrap pulses.
module counter_seq_ctrl
   import counter_seq_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH         = CSC_WIDTH,
   parameter int unsigned DEFAULT_LIMIT = CSC_DEFAULT_LIMIT
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic             Stop,
   input  logic             Hold,
   input  logic             Mode,
   input  logic [WIDTH-1:0] Limit,
   output logic [WIDTH-1:0] Count,
   output logic             Busy,
   output logic             Done,
   output logic             Wrap
);

   if (DEFAULT_LIMIT >= (64'd1 << WIDTH)) begin : g_bad_default_limit
      $error("DEFAULT_LIMIT does not fit in WIDTH bits");
   end

   state_t           r_state;
   logic [WIDTH-1:0] r_limit;
   logic             r_mode;
   logic             r_busy;
   logic             r_done;
   logic             r_wrap;

   logic             w_en;
   logic             w_clr;
   logic             w_tc;
   logic             w_run_adv;
   logic [WIDTH-1:0] w_count;

   // RUN advances only when neither Stop nor Hold takes priority this cycle.
   assign w_run_adv = (r_state == ST_RUN) && !Stop && !Hold;

   always_comb begin
      w_en  = 1'b0;
      w_clr = 1'b0;
      if (r_state == ST_IDLE && Start) begin
         w_clr = 1'b1;
      end else if (w_run_adv) begin
         if (!w_tc) begin
            w_en = 1'b1;
         end else if (r_mode) begin
            w_clr = 1'b1;
         end
      end
   end

   sync_counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .Clk   (Clk),
      .Reset (Reset),
      .En    (w_en),
      .Clr   (w_clr),
      .Limit (r_limit),
      .Count (w_count),
      .Tc    (w_tc)
   );

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= ST_IDLE;
         r_limit <= '0;
         r_mode  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         r_wrap <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (Start) begin
                  r_limit <= Limit;
                  r_mode  <= Mode;
                  r_state <= ST_RUN;
                  r_busy  <= state_is_busy(ST_RUN);
               end
            end
            ST_RUN: begin
               if (Stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= state_is_busy(ST_IDLE);
               end else if (Hold) begin
                  r_state <= ST_HOLD;
                  r_busy  <= state_is_busy(ST_HOLD);
               end else if (w_tc && !r_mode) begin
                  r_state <= ST_DONE;
                  r_busy  <= state_is_busy(ST_DONE);
                  r_done  <= 1'b1;
               end else if (w_tc) begin
                  r_wrap  <= 1'b1;
               end
            end
            ST_HOLD: begin
               if (Stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= state_is_busy(ST_IDLE);
               end else if (!Hold) begin
                  r_state <= ST_RUN;
                  r_busy  <= state_is_busy(ST_RUN);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= state_is_busy(ST_IDLE);
            end
         endcase
      end
   end

   assign Count = w_count;
   assign Busy  = r_busy;
   assign Done  = r_done;
   assign Wrap  = r_wrap;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed self-checking bench for counter_seq_ctrl.
module tb_counter_seq_ctrl;
   import counter_seq_ctrl_pkg::*;

   localparam int unsigned W = 4;

   logic         Clk = 1'b0;
   logic         Reset;
   logic         Start;
   logic         Stop;
   logic         Hold;
   logic         Mode;
   logic [W-1:0] Limit;
   logic [W-1:0] Count;
   logic         Busy;
   logic         Done;
   logic         Wrap;

   int n_pass  = 0;
   int n_fail  = 0;
   int n_total = 0;

   counter_seq_ctrl #(
      .WIDTH         (W),
      .DEFAULT_LIMIT (14)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .Start (Start),
      .Stop  (Stop),
      .Hold  (Hold),
      .Mode  (Mode),
      .Limit (Limit),
      .Count (Count),
      .Busy  (Busy),
      .Done  (Done),
      .Wrap  (Wrap)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int cnt, input int bsy, input int dn, input int wr);
      chk({tag, ".count"}, 32'(Count), 32'(cnt));
      chk({tag, ".busy"},  32'(Busy),  32'(bsy));
      chk({tag, ".done"},  32'(Done),  32'(dn));
      chk({tag, ".wrap"},  32'(Wrap),  32'(wr));
   endtask

   initial begin
      logic [3:0] exp_cnt [10];
      logic       exp_wrp [10];

      Reset = 1'b1; Start = 1'b1; Stop = 1'b0; Hold = 1'b0; Mode = 1'b0; Limit = 4'd14;

      // Reset dominates a concurrent Start
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("reset", 0, 0, 0, 0);
         chk("reset.state", 32'(dut.r_state), 32'(ST_IDLE));
      end
      Reset = 1'b0; Start = 1'b0;
      tick();
      chk_out("idle", 0, 0, 0, 0);

      // One-shot, Limit=14; Limit changed mid-run must be ignored
      Start = 1'b1; Mode = 1'b0; Limit = 4'd14;
      tick();
      Start = 1'b0; Limit = 4'd2;
      chk_out("os14.k", 0, 1, 0, 0);
      for (int n = 1; n <= 14; n++) begin
         tick();
         chk_out("os14.run", n, 1, 0, 0);
      end
      tick();
      chk_out("os14.done", 14, 0, 1, 0);
      tick();
      chk_out("os14.idle1", 14, 0, 0, 0);
      tick();
      chk_out("os14.idle2", 14, 0, 0, 0);

      // Continuous, Limit=3, ten cycles
      exp_cnt = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
      exp_wrp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      Start = 1'b1; Mode = 1'b1; Limit = 4'd3;
      tick();
      Start = 1'b0; Mode = 1'b0;
      chk_out("cont3.k", 0, 1, 0, 0);
      for (int i = 1; i < 10; i++) begin
         tick();
         chk_out("cont3.run", int'(exp_cnt[i]), 1, 0, int'(exp_wrp[i]));
      end
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      chk_out("cont3.stop", 1, 0, 0, 0);

      // One-shot, Limit=5, Hold while Count=2; Start during HOLD ignored
      Start = 1'b1; Mode = 1'b0; Limit = 4'd5;
      tick();
      Start = 1'b0;
      chk_out("hold.k", 0, 1, 0, 0);
      tick(); chk_out("hold.c1", 1, 1, 0, 0);
      tick(); chk_out("hold.c2", 2, 1, 0, 0);
      Hold = 1'b1; Start = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("hold.frozen", 2, 1, 0, 0);
         chk("hold.state", 32'(dut.r_state), 32'(ST_HOLD));
      end
      Hold = 1'b0; Start = 1'b0;
      tick();
      chk_out("hold.resume", 2, 1, 0, 0);
      tick(); chk_out("hold.c3", 3, 1, 0, 0);
      tick(); chk_out("hold.c4", 4, 1, 0, 0);
      tick(); chk_out("hold.c5", 5, 1, 0, 0);
      tick(); chk_out("hold.done", 5, 0, 1, 0);
      tick(); chk_out("hold.noqueue", 5, 0, 0, 0);

      // Stop at Count=7 with Limit=14
      Start = 1'b1; Mode = 1'b0; Limit = 4'd14;
      tick();
      Start = 1'b0;
      for (int n = 1; n <= 7; n++) tick();
      chk_out("stop.c7", 7, 1, 0, 0);
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      chk_out("stop.idle", 7, 0, 0, 0);
      tick();
      chk_out("stop.nodone", 7, 0, 0, 0);

      // Limit=0 one-shot, then Start in the IDLE cycle right after DONE
      Start = 1'b1; Limit = 4'd0;
      tick();
      Start = 1'b0;
      chk_out("lim0.k", 0, 1, 0, 0);
      tick();
      chk_out("lim0.done", 0, 0, 1, 0);
      tick();
      chk_out("lim0.idle", 0, 0, 0, 0);

      // Limit=0 continuous: Wrap every cycle, Count stays 0
      Start = 1'b1; Mode = 1'b1;
      tick();
      Start = 1'b0;
      chk_out("clim0.k", 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_out("clim0.wrap", 0, 1, 0, 1);
      end
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      chk_out("clim0.stop", 0, 0, 0, 0);

      // Reset mid-run at Count=9
      Start = 1'b1; Mode = 1'b0; Limit = 4'd14;
      tick();
      Start = 1'b0;
      for (int n = 1; n <= 9; n++) tick();
      chk_out("rst9.c9", 9, 1, 0, 0);
      Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk_out("rst9.reset", 0, 0, 0, 0);
      chk("rst9.state", 32'(dut.r_state), 32'(ST_IDLE));
      tick();
      chk_out("rst9.after", 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
